// File: rtl/calc_result_reader_if.sv
// Output stream of the result reader: one reassembled 64-bit result per beat,
// tagged with its SRAM address and an end-of-window flag.
interface calc_result_reader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   // A beat transfers on a cycle where out_valid and out_ready are both high.
   // Once out_valid is raised, it stays high and out_data/out_addr/out_last
   // stay fixed until that beat transfers; out_ready may change at any time.
   logic                  out_valid;
   logic                  out_ready;
   logic [2*DATA_W-1:0]   out_data;
   logic [ADDR_W-1:0]     out_addr;
   logic                  out_last;

   modport master (output out_valid, output out_data, output out_addr,
                   output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_addr,
                   input out_last, output out_ready);
endinterface

// File: rtl/calc_result_reader.sv
// Walks an inclusive address window of the split result SRAMs, pairs the lower
// (A) and upper (B) halves and streams the 64-bit results through a small FIFO.
module calc_result_reader #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      start_addr,
   input  logic [ADDR_W-1:0]      end_addr,
   output logic                   rd_en,
   output logic [ADDR_W-1:0]      rd_addr,
   input  logic [DATA_W-1:0]      rd_data_a,
   input  logic [DATA_W-1:0]      rd_data_b,
   calc_result_reader_if.master   out_if,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [1:0]             dbg_state
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   end_q, end_d;
   logic [ADDR_W-1:0]   infl_addr_q, infl_addr_d;
   logic                inflight_q, inflight_d;
   logic                error_q, error_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [2*DATA_W-1:0] data_mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0]   addr_mem_q [FIFO_DEPTH];
   logic                push, pop, credit_ok;
   logic [OCC_W-1:0]    occ;

   // FIFO bookkeeping; data returning from the SRAMs is pushed unconditionally
   // because credit was reserved when the read was issued.
   always_comb begin
      push                = inflight_q;
      out_if.out_valid    = (count_q != '0);
      pop                 = out_if.out_valid & out_if.out_ready;
      count_d             = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d            = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d            = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      occ                 = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
      credit_ok           = (occ < OCC_W'(FIFO_DEPTH));
      out_if.out_data     = out_if.out_valid ? data_mem_q[rd_ptr_q] : '0;
      out_if.out_addr     = out_if.out_valid ? addr_mem_q[rd_ptr_q] : '0;
      out_if.out_last     = out_if.out_valid && (addr_mem_q[rd_ptr_q] == end_q);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      end_d       = end_q;
      error_d     = error_q;
      rd_en       = 1'b0;
      done        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (start_addr <= end_addr) begin
                  addr_d  = start_addr;
                  end_d   = end_addr;
                  error_d = 1'b0;
                  state_d = S_READ;
               end else begin
                  error_d = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_READ: begin
            if (credit_ok) begin
               rd_en = 1'b1;
               // Stop on equality so a window ending at the top address never wraps.
               if (addr_q == end_q) state_d = S_DRAIN;
               else                 addr_d  = addr_q + ADDR_W'(1);
            end
         end
         S_DRAIN: begin
            if (count_d == '0) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      inflight_d  = rd_en;
      infl_addr_d = rd_en ? addr_q : infl_addr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         end_q       <= '0;
         infl_addr_q <= '0;
         inflight_q  <= 1'b0;
         error_q     <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         end_q       <= end_d;
         infl_addr_q <= infl_addr_d;
         inflight_q  <= inflight_d;
         error_q     <= error_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[wr_ptr_q] <= {rd_data_b, rd_data_a};
         addr_mem_q[wr_ptr_q] <= infl_addr_q;
      end
   end

   assign rd_addr   = addr_q;
   assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
   assign error     = error_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_calc_result_reader.sv
// Directed bench for calc_result_reader: SRAM model, stream monitor with
// ordering/stability/credit checks, and window, error and reset scenarios.
module tb_calc_result_reader;
   localparam int ADDR_W     = 10;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int DEPTH      = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] start_addr, end_addr;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data_a, rd_data_b;
   logic              busy, done, error;
   logic [1:0]        dbg_state;

   logic [DATA_W-1:0] mem_a [DEPTH];
   logic [DATA_W-1:0] mem_b [DEPTH];

   int checks = 0;
   int errors = 0;
   int beats, first_cyc, last_cyc, done_cyc, done_cnt, valid_cnt, last_cnt;
   int issued, accepted;
   logic err_at_done;

   calc_result_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) out_if ();

   calc_result_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .out_if(out_if), .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Synchronous-read SRAM pair: data appears the cycle after rd_en.
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data_a <= mem_a[rd_addr];
         rd_data_b <= mem_b[rd_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_word(input int a);
      return {mem_b[a], mem_a[a]};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"},   64'(rd_en), 64'(0));
      check({tag, "_rd_addr"}, 64'(rd_addr), 64'(0));
      check({tag, "_valid"},   64'(out_if.out_valid), 64'(0));
      check({tag, "_data"},    out_if.out_data, 64'(0));
      check({tag, "_addr"},    64'(out_if.out_addr), 64'(0));
      check({tag, "_last"},    64'(out_if.out_last), 64'(0));
      check({tag, "_busy"},    64'(busy), 64'(0));
      check({tag, "_done"},    64'(done), 64'(0));
      check({tag, "_error"},   64'(error), 64'(0));
   endtask

   // Issues one start and monitors the stream until the cycle after done,
   // or returns early once stop_beats words have been accepted.
   task automatic stream(input int s, input int e, input bit rand_ready,
                         input int stop_beats, input bit poke);
      bit          stalled, seen_done, pop;
      logic [63:0] pdata;
      logic [ADDR_W-1:0] paddr;
      logic        plast;
      int          exp_addr;
      beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
      valid_cnt = 0; last_cnt = 0; issued = 0; accepted = 0; err_at_done = 1'bx;
      stalled = 0; seen_done = 0; exp_addr = s;
      pdata = '0; paddr = '0; plast = 1'b0;
      @(negedge clk);
      start = 1'b1; start_addr = ADDR_W'(s); end_addr = ADDR_W'(e);
      out_if.out_ready = 1'b0;
      for (int cyc = 1; cyc < 3000; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         out_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (seen_done) begin
            check("done_single_pulse", 64'(done), 64'(0));
            check("idle_busy", 64'(busy), 64'(0));
            check("idle_state", 64'(dbg_state), 64'(0));
            return;
         end
         pop = out_if.out_valid && out_if.out_ready;
         if (rd_en) begin
            check("credit", 64'((issued - accepted - int'(pop)) < FIFO_DEPTH), 64'(1));
            check("rd_addr", 64'(rd_addr), 64'(s + issued));
            issued++;
         end
         if (stalled) begin
            check("stall_valid", 64'(out_if.out_valid), 64'(1));
            check("stall_data", out_if.out_data, pdata);
            check("stall_addr", 64'(out_if.out_addr), 64'(paddr));
            check("stall_last", 64'(out_if.out_last), 64'(plast));
         end
         if (out_if.out_valid) valid_cnt++;
         if (pop) begin
            check("beat_data", out_if.out_data, exp_word(exp_addr));
            check("beat_addr", 64'(out_if.out_addr), 64'(exp_addr));
            check("beat_last", 64'(out_if.out_last), 64'(exp_addr == e));
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (out_if.out_last) last_cnt++;
            beats++; accepted++; exp_addr++;
         end
         stalled = out_if.out_valid && !out_if.out_ready;
         pdata = out_if.out_data; paddr = out_if.out_addr; plast = out_if.out_last;
         if (done) begin
            done_cnt++; done_cyc = cyc; err_at_done = error; seen_done = 1;
         end
         if (stop_beats > 0 && beats == stop_beats) return;
         if (poke && cyc == 2) begin
            start = 1'b1; start_addr = ADDR_W'(100); end_addr = ADDR_W'(200);
         end
      end
      check("timeout_done", 64'(seen_done), 64'(1));
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         mem_a[a] = (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
         mem_b[a] = 32'hC0DE_0000 | 32'(a);
      end
      mem_a[768] = 32'h0000_0005;
      mem_b[768] = 32'h0000_0001;

      // Reset state
      rst = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0; out_if.out_ready = 1'b0;
      #1;
      check_all_zero("por");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("por_state", 64'(dbg_state), 64'(0));
      check("por_busy", 64'(busy), 64'(0));

      // Single-word window
      stream(768, 768, 1'b0, 0, 1'b0);
      check("one_beats", 64'(beats), 64'(1));
      check("one_first_cyc", 64'(first_cyc), 64'(3));
      check("one_last_cnt", 64'(last_cnt), 64'(1));
      check("one_done_cyc", 64'(done_cyc), 64'(4));
      check("one_done_cnt", 64'(done_cnt), 64'(1));
      check("one_word", exp_word(768), 64'h0000_0001_0000_0005);

      // Full window to the top address, ready always high
      stream(768, 1023, 1'b0, 0, 1'b0);
      check("top_beats", 64'(beats), 64'(256));
      check("top_first_cyc", 64'(first_cyc), 64'(3));
      check("top_last_cyc", 64'(last_cyc), 64'(258));
      check("top_done_cyc", 64'(done_cyc), 64'(259));
      check("top_last_cnt", 64'(last_cnt), 64'(1));
      check("top_issued", 64'(issued), 64'(256));
      check("top_rd_addr_hold", 64'(rd_addr), 64'(1023));

      // Same window with random backpressure
      stream(768, 1023, 1'b1, 0, 1'b0);
      check("rnd_beats", 64'(beats), 64'(256));
      check("rnd_issued", 64'(issued), 64'(256));
      check("rnd_last_cnt", 64'(last_cnt), 64'(1));
      check("rnd_done_cnt", 64'(done_cnt), 64'(1));

      // Reversed window flags an error without reading
      stream(10, 5, 1'b0, 0, 1'b0);
      check("err_flag", 64'(err_at_done), 64'(1));
      check("err_done_cyc", 64'(done_cyc), 64'(1));
      check("err_valid_cnt", 64'(valid_cnt), 64'(0));
      check("err_issued", 64'(issued), 64'(0));
      check("err_sticky", 64'(error), 64'(1));

      // A valid start clears the error
      stream(0, 3, 1'b0, 0, 1'b0);
      check("clr_error", 64'(error), 64'(0));
      check("clr_beats", 64'(beats), 64'(4));
      check("clr_done_cnt", 64'(done_cnt), 64'(1));

      // Reset mid-transfer after 40 beats
      stream(0, 511, 1'b0, 40, 1'b0);
      check("rst_beats_before", 64'(beats), 64'(40));
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("mid_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_state", 64'(dbg_state), 64'(0));
      check("mid_rst_busy", 64'(busy), 64'(0));
      done_cnt = 0; valid_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (done) done_cnt++;
         if (out_if.out_valid) valid_cnt++;
      end
      check("mid_rst_no_done", 64'(done_cnt), 64'(0));
      check("mid_rst_no_valid", 64'(valid_cnt), 64'(0));

      // Restart after reset, with a start pulse while busy
      stream(0, 1, 1'b0, 0, 1'b1);
      check("poke_beats", 64'(beats), 64'(2));
      check("poke_issued", 64'(issued), 64'(2));
      check("poke_last_cnt", 64'(last_cnt), 64'(1));
      check("poke_done_cnt", 64'(done_cnt), 64'(1));
      valid_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (out_if.out_valid || busy) valid_cnt++;
      end
      check("poke_no_restart", 64'(valid_cnt), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
